// File: rtl/ram_sync.sv
`default_nettype none
// ============================================================================
// Module   : ram_sync
// Purpose  : Synchronous data RAM with two registered read ports and one
//            byte-lane write port. Takes byte addresses plus an access size
//            and sign flag, and handles lane selection, sign/zero extension,
//            alignment faults and write-first forwarding internally.
//            Can zero-fill itself after reset; o_ready is high once serving.
// Ports    : i_clk, i_rst_n      - clock, asynchronous active-low reset
//            o_ready             - high in IDLE (requests accepted)
//            i_rdN_* / o_rdN_*   - read ports N=1,2: addr, en, size, signed
//                                  in; data, valid, err out (1-cycle latency)
//            i_wr_*  / o_wr_err  - write port: addr, en, size, data in;
//                                  fault pulse out (next cycle)
// Revision : 1.0 - initial release
// ============================================================================
module ram_sync #(
    parameter int    DATA_WIDTH     = 32,
    parameter int    ADDR_WIDTH     = 10,
    parameter bit    CLEAR_ON_RESET = 1'b1,
    parameter string INIT_FILE      = "ram.mem"
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    output logic                  o_ready,
    input  logic [ADDR_WIDTH-1:0] i_rd1_addr,
    input  logic                  i_rd1_en,
    input  logic [1:0]            i_rd1_size,
    input  logic                  i_rd1_signed,
    output logic [DATA_WIDTH-1:0] o_rd1_data,
    output logic                  o_rd1_valid,
    output logic                  o_rd1_err,
    input  logic [ADDR_WIDTH-1:0] i_rd2_addr,
    input  logic                  i_rd2_en,
    input  logic [1:0]            i_rd2_size,
    input  logic                  i_rd2_signed,
    output logic [DATA_WIDTH-1:0] o_rd2_data,
    output logic                  o_rd2_valid,
    output logic                  o_rd2_err,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic                  i_wr_en,
    input  logic [1:0]            i_wr_size,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_wr_err
);

    localparam int c_nb    = DATA_WIDTH / 8;
    localparam int c_off   = $clog2(c_nb);
    localparam int c_wa    = ADDR_WIDTH - c_off;
    localparam int c_depth = 1 << c_wa;
    // One extra bit so the clear counter never wraps before terminal detect.
    localparam logic [c_wa:0] c_clr_last = (c_wa + 1)'(c_depth - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic [c_wa:0] r_clr_idx;

    logic [DATA_WIDTH-1:0] r_mem [0:c_depth-1];

    logic [DATA_WIDTH-1:0] r_rd1_data, r_rd2_data;
    logic                  r_rd1_valid, r_rd2_valid;
    logic                  r_rd1_err, r_rd2_err;
    logic                  r_wr_err;

    // Faults: access wider than the word, or lane offset not size-aligned.
    function automatic logic access_fault(input logic [c_off-1:0] off,
                                          input logic [1:0]       size);
        logic f;
        f = (int'(size) > c_off);
        for (int i = 0; i < c_off; i++) begin
            if ((i < int'(size)) && off[i]) f = 1'b1;
        end
        return f;
    endfunction

    // Right-align the addressed lanes and extend above the access width.
    function automatic logic [DATA_WIDTH-1:0] extract(input logic [DATA_WIDTH-1:0] word,
                                                      input logic [c_off-1:0]      off,
                                                      input logic [1:0]            size,
                                                      input logic                  sgn);
        logic [DATA_WIDTH-1:0] sh;
        logic                  fill;
        int                    w;
        sh = word >> {off, 3'b000};
        w  = 8 << size;
        case (size)
            2'd0:    fill = sgn & sh[7];
            2'd1:    fill = sgn & sh[15];
            2'd2:    fill = sgn & sh[31];
            default: fill = sgn & sh[DATA_WIDTH-1];
        endcase
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (i >= w) sh[i] = fill;
        end
        return sh;
    endfunction

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    logic [c_wa-1:0]       w_wr_idx;
    logic [c_off-1:0]      w_wr_off;
    logic                  w_wr_fault;
    logic                  w_wr_go;
    logic [c_nb-1:0]       w_wr_be;
    logic [DATA_WIDTH-1:0] w_wr_mask;
    logic [DATA_WIDTH-1:0] w_wr_shift;
    logic [DATA_WIDTH-1:0] w_wr_merged;

    assign w_wr_idx   = i_wr_addr[ADDR_WIDTH-1:c_off];
    assign w_wr_off   = i_wr_addr[c_off-1:0];
    assign w_wr_fault = access_fault(w_wr_off, i_wr_size);
    assign w_wr_go    = (r_state == ST_IDLE) && i_wr_en && !w_wr_fault;

    always_comb begin
        w_wr_be   = '0;
        w_wr_mask = '0;
        for (int b = 0; b < c_nb; b++) begin
            w_wr_be[b] = (b >= int'(w_wr_off)) && (b < int'(w_wr_off) + (1 << i_wr_size));
            w_wr_mask[8*b +: 8] = {8{w_wr_be[b]}};
        end
    end

    assign w_wr_shift  = i_wr_data << {w_wr_off, 3'b000};
    // Post-write word; committed to the array and forwarded to same-word reads.
    assign w_wr_merged = (r_mem[w_wr_idx] & ~w_wr_mask) | (w_wr_shift & w_wr_mask);

    always_ff @(posedge i_clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_clr_idx[c_wa-1:0]] <= '0;
        end else if (w_wr_go) begin
            r_mem[w_wr_idx] <= w_wr_merged;
        end
    end

    // ------------------------------------------------------------------
    // Read paths (write-first on a same-word collision)
    // ------------------------------------------------------------------
    logic [c_wa-1:0]       w_rd1_idx, w_rd2_idx;
    logic [c_off-1:0]      w_rd1_off, w_rd2_off;
    logic                  w_rd1_fault, w_rd2_fault;
    logic [DATA_WIDTH-1:0] w_rd1_word, w_rd2_word;

    assign w_rd1_idx   = i_rd1_addr[ADDR_WIDTH-1:c_off];
    assign w_rd1_off   = i_rd1_addr[c_off-1:0];
    assign w_rd1_fault = access_fault(w_rd1_off, i_rd1_size);
    assign w_rd1_word  = (w_wr_go && (w_rd1_idx == w_wr_idx)) ? w_wr_merged : r_mem[w_rd1_idx];

    assign w_rd2_idx   = i_rd2_addr[ADDR_WIDTH-1:c_off];
    assign w_rd2_off   = i_rd2_addr[c_off-1:0];
    assign w_rd2_fault = access_fault(w_rd2_off, i_rd2_size);
    assign w_rd2_word  = (w_wr_go && (w_rd2_idx == w_wr_idx)) ? w_wr_merged : r_mem[w_rd2_idx];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            if (CLEAR_ON_RESET) r_state <= ST_CLEAR;
            else                r_state <= ST_IDLE;
            r_clr_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_CLEAR) r_clr_idx <= r_clr_idx + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: if (r_clr_idx == c_clr_last) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registered results
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd1_data  <= '0;
            r_rd1_valid <= 1'b0;
            r_rd1_err   <= 1'b0;
            r_rd2_data  <= '0;
            r_rd2_valid <= 1'b0;
            r_rd2_err   <= 1'b0;
            r_wr_err    <= 1'b0;
        end else begin
            r_rd1_valid <= 1'b0;
            r_rd1_err   <= 1'b0;
            r_rd2_valid <= 1'b0;
            r_rd2_err   <= 1'b0;
            r_wr_err    <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (i_rd1_en) begin
                    r_rd1_valid <= 1'b1;
                    r_rd1_err   <= w_rd1_fault;
                    r_rd1_data  <= w_rd1_fault ? '0 :
                                   extract(w_rd1_word, w_rd1_off, i_rd1_size, i_rd1_signed);
                end
                if (i_rd2_en) begin
                    r_rd2_valid <= 1'b1;
                    r_rd2_err   <= w_rd2_fault;
                    r_rd2_data  <= w_rd2_fault ? '0 :
                                   extract(w_rd2_word, w_rd2_off, i_rd2_size, i_rd2_signed);
                end
                r_wr_err <= i_wr_en && w_wr_fault;
            end
        end
    end

    assign o_ready     = (r_state == ST_IDLE);
    assign o_rd1_data  = r_rd1_data;
    assign o_rd1_valid = r_rd1_valid;
    assign o_rd1_err   = r_rd1_err;
    assign o_rd2_data  = r_rd2_data;
    assign o_rd2_valid = r_rd2_valid;
    assign o_rd2_err   = r_rd2_err;
    assign o_wr_err    = r_wr_err;

endmodule
`default_nettype wire

// File: tb/tb_ram_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_sync
// Purpose  : Directed self-checking bench for ram_sync (32-bit, 256 words,
//            clear on reset). Expected values are hand-computed constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_sync;

    logic        clk;
    logic        rst_n;
    logic        ready;
    logic [9:0]  rd1_addr, rd2_addr, wr_addr;
    logic        rd1_en, rd2_en, wr_en;
    logic [1:0]  rd1_size, rd2_size, wr_size;
    logic        rd1_signed, rd2_signed;
    logic [31:0] rd1_data, rd2_data, wr_data;
    logic        rd1_valid, rd2_valid, rd1_err, rd2_err, wr_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt;
    int bad;

    ram_sync #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (10),
        .CLEAR_ON_RESET (1'b1),
        .INIT_FILE      ("")
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .o_ready      (ready),
        .i_rd1_addr   (rd1_addr),
        .i_rd1_en     (rd1_en),
        .i_rd1_size   (rd1_size),
        .i_rd1_signed (rd1_signed),
        .o_rd1_data   (rd1_data),
        .o_rd1_valid  (rd1_valid),
        .o_rd1_err    (rd1_err),
        .i_rd2_addr   (rd2_addr),
        .i_rd2_en     (rd2_en),
        .i_rd2_size   (rd2_size),
        .i_rd2_signed (rd2_signed),
        .o_rd2_data   (rd2_data),
        .o_rd2_valid  (rd2_valid),
        .o_rd2_err    (rd2_err),
        .i_wr_addr    (wr_addr),
        .i_wr_en      (wr_en),
        .i_wr_size    (wr_size),
        .i_wr_data    (wr_data),
        .o_wr_err     (wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd1_en = 1'b0;
        rd2_en = 1'b0;
        wr_en  = 1'b0;
    endtask

    task automatic rd1_req(input logic [9:0] a, input logic [1:0] s, input logic sg);
        rd1_en = 1'b1; rd1_addr = a; rd1_size = s; rd1_signed = sg;
    endtask

    task automatic rd2_req(input logic [9:0] a, input logic [1:0] s, input logic sg);
        rd2_en = 1'b1; rd2_addr = a; rd2_size = s; rd2_signed = sg;
    endtask

    task automatic wr_req(input logic [9:0] a, input logic [1:0] s, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_size = s; wr_data = d;
    endtask

    // Count edges until o_ready rises, with a fixed budget.
    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 400) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1;
        idle();
        rd1_addr = '0; rd1_size = '0; rd1_signed = 1'b0;
        rd2_addr = '0; rd2_size = '0; rd2_signed = 1'b0;
        wr_addr  = '0; wr_size  = '0; wr_data    = '0;
        #2 rst_n = 1'b0;
        tick();
        tick();

        // Reset state
        check_eq("rst_ready",     ready,     32'd0);
        check_eq("rst_rd1_data",  rd1_data,  32'd0);
        check_eq("rst_rd1_valid", rd1_valid, 32'd0);
        check_eq("rst_rd1_err",   rd1_err,   32'd0);
        check_eq("rst_rd2_data",  rd2_data,  32'd0);
        check_eq("rst_rd2_valid", rd2_valid, 32'd0);
        check_eq("rst_wr_err",    wr_err,    32'd0);

        // Clear takes exactly 256 cycles
        rst_n = 1'b1;
        wait_ready(cnt);
        check_eq("clear_cycles", cnt, 32'd256);

        rd1_req(10'h3FC, 2'd2, 1'b0);
        tick(); idle();
        check_eq("clr_rd_valid", rd1_valid, 32'd1);
        check_eq("clr_rd_data",  rd1_data,  32'h00000000);
        check_eq("clr_rd_err",   rd1_err,   32'd0);

        // Sub-word reads
        wr_req(10'h010, 2'd2, 32'h80FF7F01);
        tick(); idle();
        rd1_req(10'h013, 2'd0, 1'b1);
        rd2_req(10'h012, 2'd1, 1'b0);
        tick(); idle();
        check_eq("rd_sbyte_013", rd1_data, 32'hFFFFFF80);
        check_eq("rd_uhalf_012", rd2_data, 32'h000080FF);
        rd1_req(10'h010, 2'd1, 1'b1);
        tick(); idle();
        check_eq("rd_shalf_010", rd1_data, 32'h00007F01);

        // Byte write preserves neighbours
        wr_req(10'h011, 2'd0, 32'h000000AA);
        tick(); idle();
        rd1_req(10'h010, 2'd2, 1'b0);
        tick(); idle();
        check_eq("byte_wr_merge", rd1_data, 32'h80FFAA01);

        // Write-first forwarding
        wr_req(10'h024, 2'd2, 32'hCAFEF00D);
        tick(); idle();
        wr_req(10'h020, 2'd2, 32'h12345678);
        rd1_req(10'h020, 2'd2, 1'b0);
        rd2_req(10'h024, 2'd2, 1'b0);
        tick(); idle();
        check_eq("fwd_rd1", rd1_data, 32'h12345678);
        check_eq("fwd_rd2", rd2_data, 32'hCAFEF00D);
        tick();
        check_eq("noen_valid",  rd1_valid, 32'd0);
        check_eq("noen_hold",   rd1_data,  32'h12345678);

        // Faults
        rd1_req(10'h011, 2'd1, 1'b0);
        tick(); idle();
        check_eq("flt_half_valid", rd1_valid, 32'd1);
        check_eq("flt_half_err",   rd1_err,   32'd1);
        check_eq("flt_half_data",  rd1_data,  32'd0);
        wr_req(10'h022, 2'd2, 32'hDEADBEEF);
        tick(); idle();
        check_eq("flt_wr_err", wr_err, 32'd1);
        rd1_req(10'h020, 2'd2, 1'b0);
        tick(); idle();
        check_eq("flt_wr_pulse", wr_err,   32'd0);
        check_eq("flt_wr_keep",  rd1_data, 32'h12345678);
        rd1_req(10'h000, 2'd3, 1'b0);
        tick(); idle();
        check_eq("flt_size3_err", rd1_err, 32'd1);

        // Both ports on one address
        rd1_req(10'h020, 2'd2, 1'b0);
        rd2_req(10'h020, 2'd2, 1'b0);
        tick(); idle();
        check_eq("same_rd1", rd1_data, 32'h12345678);
        check_eq("same_rd2", rd2_data, 32'h12345678);

        // Asynchronous reset mid-access clears outputs without a clock edge
        rd1_req(10'h020, 2'd2, 1'b0);
        rst_n = 1'b0;
        #1;
        idle();
        check_eq("async_rd1_data",  rd1_data,  32'd0);
        check_eq("async_rd2_data",  rd2_data,  32'd0);
        check_eq("async_rd1_valid", rd1_valid, 32'd0);
        check_eq("async_ready",     ready,     32'd0);
        tick();
        rst_n = 1'b1;

        // Reset mid-clear at cycle 100
        for (int i = 0; i < 100; i++) tick();
        check_eq("midclr_ready_pre", ready, 32'd0);
        rst_n = 1'b0;
        #1;
        check_eq("midclr_ready",  ready,     32'd0);
        check_eq("midclr_valid",  rd1_valid, 32'd0);
        check_eq("midclr_wr_err", wr_err,    32'd0);
        tick();

        // Requests held through the restarted clear must be ignored
        rd1_req(10'h000, 2'd2, 1'b0);
        wr_req(10'h000, 2'd2, 32'hFFFFFFFF);
        rst_n = 1'b1;
        cnt = 0;
        bad = 0;
        while (!ready && cnt < 400) begin
            tick();
            cnt++;
            if (rd1_valid || rd1_err || wr_err) bad++;
        end
        idle();
        check_eq("reclear_cycles", cnt, 32'd256);
        check_eq("clear_ignores",  bad, 32'd0);

        rd1_req(10'h000, 2'd2, 1'b0);
        rd2_req(10'h020, 2'd2, 1'b0);
        tick(); idle();
        check_eq("clear_dropped_wr", rd1_data, 32'h00000000);
        check_eq("clear_zeroed",     rd2_data, 32'h00000000);
        check_eq("post_clr_valid",   rd2_valid, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
